// File: rtl/keypad_entry_pkg.sv
// keypad_entry_pkg: shared state encoding, digit limits and entry validity check for keypad_entry
package keypad_entry_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    LOADED = 2'd2,
    RUN    = 2'd3
  } state_t;
  localparam logic [1:0] MAX_DIGITS   = 2'd3;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  function automatic logic time_ok(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    return ({m, t, o} != 12'd0) && (t <= SEC_TENS_MAX);
  endfunction
endpackage

// File: rtl/digit_shift3.sv
// digit_shift3: three-digit BCD shift register, new digit enters at the ones position
module digit_shift3 (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift,
  input  logic       clr,
  input  logic [3:0] din,
  output logic [3:0] q2,
  output logic [3:0] q1,
  output logic [3:0] q0
);
  // clear outranks shift so a discarded entry never admits a digit
  always_ff @(posedge clk)
    if (!reset || clr) {q2, q1, q0} <= '0;
    else if (shift) {q2, q1, q0} <= {q1, q0, din};
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: keypad time entry for a countdown timer; KEYPAD_ENTRY_TIMEOUT_EN adds an entry idle auto-clear
module keypad_entry import keypad_entry_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       start,
  input  logic       clear,
  input  logic       busy,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       err,
  output logic [1:0] state_o
);
  state_t state, state_n;
  logic [1:0] ndig, ndig_n;
  logic shift, zero, load_n, err_n, key_ok, tmo;
  assign key_ok = key_valid && key <= BCD_MAX && ndig < MAX_DIGITS && (state == IDLE || state == ENTRY);
  // next state: clear > start > key > timeout > counter handshake
  always_comb begin
    state_n = state;
    ndig_n  = ndig;
    shift   = 1'b0;
    zero    = 1'b0;
    load_n  = 1'b0;
    err_n   = 1'b0;
    if (clear || (tmo && !(start && state == ENTRY) && !key_ok) || (state == RUN && !busy)) begin
      zero    = 1'b1;
      ndig_n  = '0;
      state_n = IDLE;
    end else if (start && state == ENTRY) begin
      load_n  = time_ok(min_ones, sec_tens, sec_ones);
      err_n   = !load_n;
      state_n = load_n ? LOADED : ENTRY;
    end else if (key_ok) begin
      shift   = 1'b1;
      ndig_n  = ndig + 2'd1;
      state_n = ENTRY;
    end else if (state == LOADED && busy) begin
      state_n = RUN;
    end
  end
  // state, digit count and one-cycle pulses
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      ndig  <= '0;
      load  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      ndig  <= ndig_n;
      load  <= load_n;
      err   <= err_n;
    end
  digit_shift3 u_digits (
    .clk  (clk),
    .reset(reset),
    .shift(shift),
    .clr  (zero),
    .din  (key),
    .q2   (min_ones),
    .q1   (sec_tens),
    .q0   (sec_ones)
  );
  assign state_o = state;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("keypad_entry: TIMEOUT_CYCLES must be at least 1");
  end
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  assign tmo = state == ENTRY && idle_cnt >= TW'(TIMEOUT_CYCLES - 1);
  // idle cycles spent in ENTRY; any accepted key restarts the count
  always_ff @(posedge clk)
    if (!reset) idle_cnt <= '0;
    else idle_cnt <= (state_n != ENTRY || shift) ? '0 : idle_cnt + TW'(1);
`else
  assign tmo = 1'b0;
`endif
endmodule
